// File: rtl/sram_arbiter_pkg.sv
// Shared types and defaults for the SRAM arbiter: bus widths, FSM encoding, grant type.
package sram_arbiter_pkg;

  localparam int unsigned DefaultAddrW = 18;
  localparam int unsigned DefaultDataW = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } arb_state_e;

  typedef enum logic {
    GrantRd = 1'b0,
    GrantWr = 1'b1
  } grant_e;

endpackage

// File: rtl/sram_wr_fifo.sv
// Synchronous write FIFO with a registered head word that is valid whenever o_empty is low.
module sram_wr_fifo
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned Width = DefaultAddrW + DefaultDataW,
  parameter int unsigned Depth = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [Width-1:0]       i_data,
  output logic [Width-1:0]       o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(Depth):0] o_level
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [LvlW-1:0]  r_level;
  logic [Width-1:0] r_head;
  logic [PtrW-1:0]  w_rd_next;

  assign w_rd_next = r_rd_ptr + PtrW'(1);
  assign o_full    = (r_level == LvlW'(Depth));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_head    = r_head;

  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_head   <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (i_pop)  r_rd_ptr <= w_rd_next;
      if (i_push && !i_pop) begin
        r_level <= r_level + LvlW'(1);
      end else if (!i_push && i_pop) begin
        r_level <= r_level - LvlW'(1);
      end
      // Head follows the next entry; with one entry left only a same-cycle push can refill it.
      if (i_pop) begin
        if (r_level == LvlW'(1)) r_head <= i_data;
        else                     r_head <= r_mem[w_rd_next];
      end else if (o_empty && i_push) begin
        r_head <= i_data;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Sole driver of the SRAM controller: merges a priority video read port with a FIFO-buffered
// pixel write port, bounding consecutive reads so queued writes always make progress.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefaultAddrW,
  parameter int unsigned DATA_W     = DefaultDataW,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned READ_RUN   = 4
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_rd_req,
  input  logic [ADDR_W-1:0]           i_rd_addr,
  output logic                        o_rd_ack,
  output logic                        o_rd_valid,
  output logic [DATA_W-1:0]           o_rd_data,
  input  logic                        i_wr_valid,
  output logic                        o_wr_ready,
  input  logic [ADDR_W-1:0]           i_wr_addr,
  input  logic [DATA_W-1:0]           i_wr_data,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_level,
  output logic                        o_sram_write,
  output logic                        o_sram_read,
  output logic [ADDR_W-1:0]           o_sram_address,
  output logic [DATA_W-1:0]           o_sram_data_write,
  input  logic [DATA_W-1:0]           i_sram_data_read,
  input  logic                        i_sram_ready
);

  localparam int unsigned FifoW = ADDR_W + DATA_W;
  localparam int unsigned RunW  = $clog2(READ_RUN + 1);

  arb_state_e          r_state, w_state_d;
  grant_e              r_grant;
  logic [RunW-1:0]     r_run_cnt;
  logic                r_sram_read, r_sram_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_rd_ack, r_rd_valid;
  logic [DATA_W-1:0]   r_rd_data;

  logic                w_grant_rd, w_grant_wr;
  logic                w_push, w_fifo_full, w_fifo_empty;
  logic [FifoW-1:0]    w_fifo_head;

  assign w_push     = i_wr_valid && !w_fifo_full;
  assign o_wr_ready = !w_fifo_full;

  sram_wr_fifo #(
    .Width (FifoW),
    .Depth (FIFO_DEPTH)
  ) u_wr_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_pop   (w_grant_wr),
    .i_data  ({i_wr_addr, i_wr_data}),
    .o_head  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (o_fifo_level)
  );

  always_comb begin
    w_state_d  = r_state;
    w_grant_rd = 1'b0;
    w_grant_wr = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_sram_ready) begin
          if ((r_run_cnt == RunW'(READ_RUN)) && !w_fifo_empty) w_grant_wr = 1'b1;
          else if (i_rd_req)                                    w_grant_rd = 1'b1;
          else if (!w_fifo_empty)                               w_grant_wr = 1'b1;
          if (w_grant_rd || w_grant_wr) w_state_d = StIssue;
        end
      end
      StIssue: w_state_d = StWait;
      StWait:  if (i_sram_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_grant      <= GrantRd;
      r_run_cnt    <= '0;
      r_sram_read  <= 1'b0;
      r_sram_write <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rd_ack     <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
    end else begin
      r_state      <= w_state_d;
      r_sram_read  <= w_grant_rd;
      r_sram_write <= w_grant_wr;
      r_rd_ack     <= w_grant_rd;
      r_rd_valid   <= 1'b0;
      if (w_grant_rd) begin
        r_grant   <= GrantRd;
        r_addr    <= i_rd_addr;
        // Reads only count toward the run limit while writes are actually waiting.
        r_run_cnt <= w_fifo_empty ? '0 : r_run_cnt + RunW'(1);
      end
      if (w_grant_wr) begin
        r_grant   <= GrantWr;
        r_addr    <= w_fifo_head[FifoW-1:DATA_W];
        r_wdata   <= w_fifo_head[DATA_W-1:0];
        r_run_cnt <= '0;
      end
      if ((r_state == StWait) && i_sram_ready && (r_grant == GrantRd)) begin
        r_rd_data  <= i_sram_data_read;
        r_rd_valid <= 1'b1;
      end
    end
  end

  assign o_sram_read       = r_sram_read;
  assign o_sram_write      = r_sram_write;
  assign o_sram_address    = r_addr;
  assign o_sram_data_write = r_wdata;
  assign o_rd_ack          = r_rd_ack;
  assign o_rd_valid        = r_rd_valid;
  assign o_rd_data         = r_rd_data;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: expected SRAM transactions and read data are queued by the
// stimulus, and a negedge monitor checks every strobe and rd_valid pulse against them.
module tb_sram_arbiter;

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 16;

  typedef struct packed {
    logic          is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  logic clk = 1'b0;
  logic reset;
  logic rd_req, rd_ack, rd_valid;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [3:0] fifo_level;
  logic sram_write, sram_read;
  logic [AW-1:0] sram_address;
  logic [DW-1:0] sram_data_write;
  logic [DW-1:0] sram_data_read = '0;
  logic sram_ready = 1'b0;

  always #5 clk = ~clk;

  sram_arbiter dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_rd_req          (rd_req),
    .i_rd_addr         (rd_addr),
    .o_rd_ack          (rd_ack),
    .o_rd_valid        (rd_valid),
    .o_rd_data         (rd_data),
    .i_wr_valid        (wr_valid),
    .o_wr_ready        (wr_ready),
    .i_wr_addr         (wr_addr),
    .i_wr_data         (wr_data),
    .o_fifo_level      (fifo_level),
    .o_sram_write      (sram_write),
    .o_sram_read       (sram_read),
    .o_sram_address    (sram_address),
    .o_sram_data_write (sram_data_write),
    .i_sram_data_read  (sram_data_read),
    .i_sram_ready      (sram_ready)
  );

  // Controller model: accepts a strobe while idle, busy for 4 cycles, ready again on the 5th.
  logic [DW-1:0] mem [logic [AW-1:0]];
  int busy = 0;
  always @(posedge clk) begin
    if (reset) begin
      sram_ready <= 1'b0;
      busy       <= 0;
    end else if (sram_ready && (sram_read || sram_write)) begin
      sram_ready <= 1'b0;
      busy       <= 3;
      if (sram_write) mem[sram_address] = sram_data_write;
      else sram_data_read <= mem.exists(sram_address) ? mem[sram_address] : '0;
    end else if (!sram_ready) begin
      if (busy == 0) sram_ready <= 1'b1;
      else           busy <= busy - 1;
    end
  end

  txn_t          exp_txn[$];
  logic [DW-1:0] exp_rd[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cycle    = 0;
  int last_issue = 0;
  int n_wr_seen  = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
  endfunction

  function automatic void exp_r(input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    t.is_wr = 1'b0; t.addr = a; t.data = '0;
    exp_txn.push_back(t);
    exp_rd.push_back(d);
  endfunction

  function automatic void exp_w(input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    t.is_wr = 1'b1; t.addr = a; t.data = d;
    exp_txn.push_back(t);
  endfunction

  function automatic logic [DW-1:0] dpat(input int i);
    return 16'h3000 + 16'(i) * 16'h0101;
  endfunction

  // Monitor
  always @(negedge clk) begin
    txn_t t;
    cycle++;
    if (sram_read || sram_write) begin
      check("strobe_exclusive", 32'(sram_read && sram_write), 32'd0);
      check("strobe_while_ready", 32'(sram_ready), 32'd1);
      check("txn_expected", 32'(exp_txn.size() != 0), 32'd1);
      if (exp_txn.size() != 0) begin
        t = exp_txn.pop_front();
        check("txn_kind", 32'(sram_write), 32'(t.is_wr));
        check("txn_addr", 32'(sram_address), 32'(t.addr));
        if (t.is_wr) check("txn_wdata", 32'(sram_data_write), 32'(t.data));
      end
      if (sram_read) last_issue = cycle;
      if (sram_write) n_wr_seen++;
    end
    if (rd_ack) check("rd_ack_with_read_issue", 32'(sram_read), 32'd1);
    if (rd_valid) begin
      check("rd_valid_latency", 32'(cycle - last_issue), 32'd6);
      check("rd_valid_expected", 32'(exp_rd.size() != 0), 32'd1);
      if (exp_rd.size() != 0) check("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
    end
  end

  task automatic wait_ack();
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (rd_ack) seen = 1'b1;
    end
    check("rd_ack_timeout", 32'(seen), 32'd1);
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    bit seen = 1'b0;
    rd_req = 1'b1; rd_addr = a;
    wait_ack();
    @(posedge clk); #1;
    rd_req = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (rd_valid) seen = 1'b1;
    end
    check("rd_valid_timeout", 32'(seen), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int g = 0;
    while (!wr_ready && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    check("push_ready_timeout", 32'(wr_ready), 32'd1);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int target;
    reset = 1'b1; rd_req = 1'b0; rd_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    mem[18'h00123] = 16'hBEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_sram_rw", 32'({sram_read, sram_write}), 32'd0);
    check("rst_sram_address", 32'(sram_address), 32'd0);
    check("rst_sram_data_write", 32'(sram_data_write), 32'd0);
    check("rst_rd_pulses", 32'({rd_ack, rd_valid}), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single read
    exp_r(18'h00123, 16'hBEEF);
    do_read(18'h00123);
    repeat (3) @(negedge clk);
    check("rd_data_held", 32'(rd_data), 32'hBEEF);
    @(posedge clk); #1;

    // Single write
    exp_w(18'h3FFFF, 16'hA5A5);
    push_wr(18'h3FFFF, 16'hA5A5);
    @(negedge clk);
    check("single_wr_level1", 32'(fifo_level), 32'd1);
    g = 0;
    while (fifo_level != 0 && g < 50) begin @(negedge clk); g++; end
    check("single_wr_level0", 32'(fifo_level), 32'd0);
    repeat (10) @(negedge clk);
    check("single_wr_mem", 32'(mem.exists(18'h3FFFF) ? mem[18'h3FFFF] : 16'h0), 32'hA5A5);
    @(posedge clk); #1;

    // Fill FIFO under continuous reads, then starvation guard drains it: R, then (RRRR W) x8
    exp_r(18'h00123, 16'hBEEF);
    for (int w = 0; w < 8; w++) begin
      for (int r = 0; r < 4; r++) exp_r(18'h00123, 16'hBEEF);
      exp_w(18'h00200 + 18'(w), 16'h7A00 + 16'(w));
    end
    target = n_wr_seen + 8;
    rd_req = 1'b1; rd_addr = 18'h00123;
    wait_ack();
    @(posedge clk); #1;
    for (int k = 0; k < 9; k++) begin
      wr_valid = 1'b1; wr_addr = 18'h00200 + 18'(k); wr_data = 16'h7A00 + 16'(k);
      @(negedge clk);
      check(k < 8 ? "fill_wr_ready" : "full_wr_ready", 32'(wr_ready), 32'(k < 8));
      check("fill_level", 32'(fifo_level), 32'(k));
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    @(negedge clk);
    check("full_level_after_refused", 32'(fifo_level), 32'd8);
    g = 0;
    while (n_wr_seen < target && g < 600) begin @(negedge clk); g++; end
    check("starve_drain_timeout", 32'(n_wr_seen), 32'(target));
    @(posedge clk); #1;
    rd_req = 1'b0;
    repeat (10) @(posedge clk); #1;

    // Simultaneous push+pop at level 3, then read back addresses 0..15
    exp_r(18'h00123, 16'hBEEF);
    for (int i = 0; i < 16; i++) exp_w(18'(i), dpat(i));
    target = n_wr_seen + 16;
    rd_req = 1'b1; rd_addr = 18'h00123;
    wait_ack();
    @(posedge clk); #1;
    rd_req = 1'b0;
    for (int i = 0; i < 3; i++) push_wr(18'(i), dpat(i));
    @(posedge clk); #1;
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_addr = 18'd3; wr_data = dpat(3);
    @(negedge clk);
    check("pushpop_level_before", 32'(fifo_level), 32'd3);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    @(negedge clk);
    check("pushpop_level_after", 32'(fifo_level), 32'd3);
    @(posedge clk); #1;
    for (int i = 4; i < 16; i++) push_wr(18'(i), dpat(i));
    g = 0;
    while (n_wr_seen < target && g < 300) begin @(negedge clk); g++; end
    check("pushpop_drain_timeout", 32'(n_wr_seen), 32'(target));
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      exp_r(18'(i), dpat(i));
      do_read(18'(i));
    end

    // Reset during WAIT of a read, with a write still queued
    begin
      txn_t t;
      t.is_wr = 1'b0; t.addr = 18'd5; t.data = '0;
      exp_txn.push_back(t);
    end
    rd_req = 1'b1; rd_addr = 18'd5;
    wait_ack();
    @(posedge clk); #1;
    rd_req = 1'b0;
    wr_valid = 1'b1; wr_addr = 18'h00300; wr_data = 16'hDEAD;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_fifo_level", 32'(fifo_level), 32'd0);
    check("mid_rst_wr_ready", 32'(wr_ready), 32'd1);
    check("mid_rst_sram_rw", 32'({sram_read, sram_write}), 32'd0);
    check("mid_rst_sram_address", 32'(sram_address), 32'd0);
    check("mid_rst_sram_data_write", 32'(sram_data_write), 32'd0);
    check("mid_rst_rd_pulses", 32'({rd_ack, rd_valid}), 32'd0);
    check("mid_rst_rd_data", 32'(rd_data), 32'd0);
    @(posedge clk); #1;
    exp_r(18'd5, dpat(5));
    do_read(18'd5);

    repeat (20) @(negedge clk);
    check("txn_queue_empty", 32'(exp_txn.size()), 32'd0);
    check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Sits directly upstream of the SRAM controller and is the only block that drives its write/read/address/data_write inputs.
- Merges two clients:
  - Video line-prefetch read port: latency-critical, highest priority.
  - Pixel-draw write port: buffered in a small FIFO so the drawing logic never stalls on SRAM timing.
- Returns read data to the video client and guarantees writes are not starved.

Parameters:
ADDR_W, 18, SRAM word address width
DATA_W, 16, SRAM data width
FIFO_DEPTH, 8, write FIFO entries; power of 2, at least 2
READ_RUN, 4, max consecutive reads granted while writes are pending

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
rd_req  in  1  read request; held with rd_addr stable until rd_ack
rd_addr  in  ADDR_W  read word address
rd_ack  out  1  one-cycle pulse: read accepted, client may change rd_req/rd_addr
rd_valid  out  1  one-cycle pulse: rd_data holds the completed read
rd_data  out  DATA_W  last read word; held until the next read completes
wr_valid  in  1  write offer
wr_ready  out  1  FIFO not full; a push happens when wr_valid and wr_ready
wr_addr  in  ADDR_W  write word address
wr_data  in  DATA_W  write data
fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
sram_write  out  1  write strobe to controller
sram_read  out  1  read strobe to controller
sram_address  out  ADDR_W  address to controller
sram_data_write  out  DATA_W  write data to controller
sram_data_read  in  DATA_W  controller read result
sram_ready  in  1  controller idle; low while busy and during reset

Behaviour:
- Reset (synchronous, active-high), all registered, values on the first cycle after reset:
  - State is IDLE; the FIFO is emptied, so fifo_level=0 and wr_ready=1.
  - sram_write=0, sram_read=0, sram_address=0, sram_data_write=0.
  - rd_ack=0, rd_valid=0, rd_data=0; the run counter is 0.
  - Reset mid-access abandons the access; no rd_valid is produced. The controller shares this reset.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE → ISSUE when sram_ready=1 and a request is pending. Grant rules:
    - If run_cnt==READ_RUN and the FIFO is non-empty: grant the FIFO head (pop), set run_cnt=0.
    - Else if rd_req: grant the read; run_cnt += 1 if the FIFO is non-empty, else run_cnt=0.
    - Else if the FIFO is non-empty: grant the head (pop), set run_cnt=0.
    - Register address/data on the grant; set exactly one of sram_read/sram_write for the ISSUE cycle.
  - ISSUE (exactly 1 cycle):
    - Strobe is high and the controller samples it.
    - rd_ack=1 if the grant was a read.
    - Next state is WAIT; the strobe clears.
  - WAIT: stay while sram_ready=0. The first WAIT cycle always sees sram_ready=0, because the controller has left idle. When sram_ready=1:
    - If the access was a read, capture sram_data_read into rd_data and pulse rd_valid on the next cycle.
    - Go to IDLE.
- Correctness depends only on the sram_ready handshake, never on cycle counts. With the current controller, IDLE-decision to next IDLE-decision is 7 clocks for both reads and writes. rd_valid asserts 7 clocks after the grant cycle, i.e. 6 after rd_ack.
- The strobe is never asserted while sram_ready=0. Read and write strobes are never asserted together.
- sram_address/sram_data_write hold their values from ISSUE through WAIT.
- FIFO rules:
  - Push when wr_valid and wr_ready; pop only in IDLE on a write grant.
  - Simultaneous push and pop is allowed; fifo_level is unchanged.
  - When full, wr_ready=0 even if a pop occurs in that same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_level counts 0..FIFO_DEPTH inclusive.
- rd_req with rd_ack pending: the client holds rd_req, so the arbiter does not resample it until back in IDLE.
- Data bit 13 is unreliable on this board. The arbiter passes it through unmodified; masking or avoiding it is the clients' job.

Decomposition:
- Shared package holds:
  - ADDR_W/DATA_W defaults.
  - FSM state encodings: IDLE=0, ISSUE=1, WAIT=2.
  - A grant-type constant: GRANT_RD=0, GRANT_WR=1.
- One sub-module, sram_wr_fifo: synchronous FIFO, width ADDR_W+DATA_W, depth FIFO_DEPTH.
  - Inputs: push, pop. Outputs: full, empty, level.
  - Head is registered and valid whenever empty=0.

Test Plan:
- Single read: controller model preloaded with mem[0x00123]=0xBEEF; rd_req, rd_addr=0x00123 → rd_ack 1 clock after the grant, rd_valid 7 clocks after the grant, rd_data=0xBEEF held afterwards.
- Single write: push (0x3FFFF, 0xA5A5) → one sram_write pulse with sram_address=0x3FFFF, sram_data_write=0xA5A5; fifo_level 1→0; model memory updated.
- Fill FIFO: 9 back-to-back pushes with rd_req held high → wr_ready=0 after the 8th push, 9th push refused; fifo_level=8 reached.
- Starvation guard: rd_req held continuously with 3 writes queued → grant order is R,R,R,R,W,R,R,R,R,W,... (READ_RUN=4); no two strobes overlap.
- Simultaneous push+pop at level 3 → level stays 3; write ordering preserved; verify by reading back addresses 0..15 after writing distinct data.
- Reset asserted during WAIT of a read → no rd_valid; all outputs at reset values the next cycle; fifo_level=0; a subsequent read completes normally.
